pipeline_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB). It tracks destination registers of in-flight instructions and generates stall, flush, freeze and forwarding-select controls. It also sequences a drain-and-halt on SYSTEM instructions. It sits beside the decoder and drives the enables and clears of the pipeline registers and the EX operand muxes.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 42 ++++
 rtl/pipeline_hazard_ctrl_if.sv | 36 +++
 rtl/pipeline_hazard_ctrl_hazard_decode.sv | 38 +++
 rtl/pipeline_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline hazard controller.
// Holds the opcode encoding, the forwarding-select encoding, the controller
// state type and the scoreboard entry layout.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_ADDR_WIDTH = 5;

  // Asserted level of the synchronous reset.
  localparam logic RESET = 1'b0;

  typedef enum logic [6:0] {
    LOAD    = 7'b0000011,
    OP_IMM  = 7'b0010011,
    U_AUIPC = 7'b0010111,
    STORE   = 7'b0100011,
    OP      = 7'b0110011,
    U_LUI   = 7'b0110111,
    BRANCH  = 7'b1100011,
    JALR    = 7'b1100111,
    J_JAL   = 7'b1101111,
    SYSTEM  = 7'b1110011
  } instruction_format_type;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    EX_MEM = 2'd1,
    MEM_WB = 2'd2
  } FORWARDING_TYPE;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hazard_state_type;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      wr;
    logic                      load;
  } sb_entry_type;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the decode/pipeline datapath and the hazard controller.
//   master : datapath side, drives ID fields, ex_redirect, mem_busy;
//            receives stage enables/clears, forwarding selects, halted.
//   slave  : hazard controller side.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      id_valid;
  logic [6:0]                id_opcode;
  logic [REG_ADDR_WIDTH-1:0] id_rs1;
  logic [REG_ADDR_WIDTH-1:0] id_rs2;
  logic [REG_ADDR_WIDTH-1:0] id_rd;
  logic                      ex_redirect;
  logic                      mem_busy;

  logic                      pc_en;
  logic                      if_id_en;
  logic                      if_id_flush;
  logic                      id_ex_flush;
  logic                      pipe_freeze;
  pipeline_hazard_ctrl_pkg::FORWARDING_TYPE fwd_a;
  pipeline_hazard_ctrl_pkg::FORWARDING_TYPE fwd_b;
  logic                      halted;

  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_redirect, mem_busy,
    input  pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_freeze,
           fwd_a, fwd_b, halted
  );

  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_redirect, mem_busy,
    output pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_freeze,
           fwd_a, fwd_b, halted
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_decode.sv
// Opcode classifier for hazard detection (purely combinational).
//   opcode    : ID opcode
//   rd_nz     : ID destination is not x0
//   uses_rs1  : instruction reads rs1
//   uses_rs2  : instruction reads rs2
//   writes_rd : instruction writes a real register (never x0)
//   is_load   : instruction is a LOAD
module pipeline_hazard_ctrl_hazard_decode
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic       rd_nz,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       writes_rd,
  output logic       is_load
);

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    case (opcode)
      OP:      begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = rd_nz; end
      OP_IMM:  begin uses_rs1 = 1'b1; writes_rd = rd_nz; end
      LOAD:    begin uses_rs1 = 1'b1; writes_rd = rd_nz; is_load = 1'b1; end
      STORE:   begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      BRANCH:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      JALR:    begin uses_rs1 = 1'b1; writes_rd = rd_nz; end
      J_JAL:   writes_rd = rd_nz;
      U_LUI:   writes_rd = rd_nz;
      U_AUIPC: writes_rd = rd_nz;
      default: ;  // SYSTEM and unknown opcodes neither read nor write
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline.
// Tracks destinations of the instructions in EX and MEM, detects load-use,
// registers EX operand forwarding selects, applies redirect flushes and the
// memory freeze, and drains then halts the pipe after a SYSTEM instruction.
//   clk   : clock, all state on rising edge
//   reset : synchronous, active low
//   bus   : slave side of pipeline_hazard_ctrl_if (ID fields, redirect,
//           mem_busy in; stage enables/clears, fwd_a/fwd_b, halted out)
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::RESET, pipeline_hazard_ctrl_pkg::SYSTEM,
         pipeline_hazard_ctrl_pkg::FORWARDING_TYPE, pipeline_hazard_ctrl_pkg::NONE,
         pipeline_hazard_ctrl_pkg::EX_MEM, pipeline_hazard_ctrl_pkg::MEM_WB,
         pipeline_hazard_ctrl_pkg::hazard_state_type, pipeline_hazard_ctrl_pkg::RUN,
         pipeline_hazard_ctrl_pkg::DRAIN, pipeline_hazard_ctrl_pkg::HALTED,
         pipeline_hazard_ctrl_pkg::sb_entry_type;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DRAIN_CYCLES   = 3
) (
  input logic                 clk,
  input logic                 reset,
  pipeline_hazard_ctrl_if.slave bus
);

  logic uses_rs1, uses_rs2, writes_rd, is_load;

  pipeline_hazard_ctrl_hazard_decode u_decode (
    .opcode    (bus.id_opcode),
    .rd_nz     (bus.id_rd != '0),
    .uses_rs1  (uses_rs1),
    .uses_rs2  (uses_rs2),
    .writes_rd (writes_rd),
    .is_load   (is_load)
  );

  sb_entry_type              sb_ex;
  logic [REG_ADDR_WIDTH-1:0] mem_rd;
  logic                      mem_wr;
  hazard_state_type          state;
  logic [2:0]                cnt;
  FORWARDING_TYPE            fwd_a_q, fwd_b_q;
  FORWARDING_TYPE            fwd_a_d, fwd_b_d;

  logic frozen, load_use, issue;

  // HALTED behaves as a permanent freeze until reset.
  assign frozen = bus.mem_busy | (state == HALTED);

  assign load_use = bus.id_valid & sb_ex.load & sb_ex.wr &
                    ((uses_rs1 & (bus.id_rs1 == sb_ex.rd)) |
                     (uses_rs2 & (bus.id_rs2 == sb_ex.rd)));

  assign issue = bus.id_valid & ~frozen & ~bus.ex_redirect &
                 (state == RUN) & ~load_use;

  // Selects are evaluated against the entries as they stand now: the EX entry
  // will sit in EX/MEM and the MEM entry in MEM/WB when this operand reaches EX.
  // wr is never set for x0, so a zero source cannot match.
  function automatic FORWARDING_TYPE fwd_sel(input logic used,
                                             input logic [REG_ADDR_WIDTH-1:0] src);
    if (!used || src == '0)            return NONE;
    if (sb_ex.wr && sb_ex.rd == src)   return EX_MEM;
    if (mem_wr && mem_rd == src)       return MEM_WB;
    return NONE;
  endfunction

  assign fwd_a_d = fwd_sel(uses_rs1, bus.id_rs1);
  assign fwd_b_d = fwd_sel(uses_rs2, bus.id_rs2);

  always_comb begin
    bus.pc_en       = 1'b0;
    bus.if_id_en    = 1'b0;
    bus.if_id_flush = 1'b0;
    bus.id_ex_flush = 1'b0;
    bus.pipe_freeze = 1'b0;
    if (reset == RESET) begin
      bus.if_id_flush = 1'b1;
      bus.id_ex_flush = 1'b1;
    end else if (frozen) begin
      bus.pipe_freeze = 1'b1;
    end else if (bus.ex_redirect) begin
      // Fetch the target; both younger stages are squashed.
      bus.pc_en       = 1'b1;
      bus.if_id_en    = 1'b1;
      bus.if_id_flush = 1'b1;
      bus.id_ex_flush = 1'b1;
    end else if (state == DRAIN || load_use) begin
      bus.id_ex_flush = 1'b1;
    end else begin
      bus.pc_en    = 1'b1;
      bus.if_id_en = 1'b1;
    end
  end

  assign bus.fwd_a  = fwd_a_q;
  assign bus.fwd_b  = fwd_b_q;
  assign bus.halted = (state == HALTED);

  always_ff @(posedge clk) begin
    if (reset == RESET) begin
      state   <= RUN;
      cnt     <= '0;
      sb_ex   <= '0;
      mem_rd  <= '0;
      mem_wr  <= 1'b0;
      fwd_a_q <= NONE;
      fwd_b_q <= NONE;
    end else if (!frozen) begin
      mem_rd <= sb_ex.rd;
      mem_wr <= sb_ex.wr;
      if (issue) begin
        sb_ex   <= '{rd: bus.id_rd, wr: writes_rd, load: is_load};
        fwd_a_q <= fwd_a_d;
        fwd_b_q <= fwd_b_d;
      end else begin
        sb_ex   <= '0;
        fwd_a_q <= NONE;
        fwd_b_q <= NONE;
      end
      case (state)
        RUN: begin
          if (issue && bus.id_opcode == SYSTEM) begin
            state <= DRAIN;
            cnt   <= 3'(DRAIN_CYCLES - 1);
          end
        end
        DRAIN: begin
          // An older taken branch squashes the SYSTEM that started the drain.
          if (bus.ex_redirect)  state <= RUN;
          else if (cnt == '0)   state <= HALTED;
          else                  cnt   <= cnt - 3'd1;
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  localparam int DC = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_ADDR_WIDTH(5)) bus ();

  pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(5), .DRAIN_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [4:0] ctl;  // pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_freeze
    logic [1:0] fa;
    logic [1:0] fb;
    logic       halted;
  } outs_t;

  typedef struct {
    logic rst, v;
    logic [6:0] op;
    logic [4:0] rs1, rs2, rd;
    logic redir, busy;
    outs_t exp;
  } vec_t;

  localparam logic [4:0] C_N = 5'b11000, C_S = 5'b00010, C_R = 5'b11110,
                         C_F = 5'b00001, C_Z = 5'b00110;
  localparam logic [6:0] O_OP = 7'h33, O_IMM = 7'h13, O_LD = 7'h03, O_ST = 7'h23,
                         O_BR = 7'h63, O_JALR = 7'h67, O_JAL = 7'h6F, O_LUI = 7'h37,
                         O_AUI = 7'h17, O_SYS = 7'h73;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: contents of the EX and MEM stages as whole instructions,
  // a run/drain/halt mode and the number of drain cycles left.
  bit         m_ex_v, m_mem_v;
  logic [6:0] m_ex_op, m_mem_op;
  logic [4:0] m_ex_rd, m_mem_rd;
  int         m_mode;   // 0 run, 1 drain, 2 halted
  int         m_left;
  logic [1:0] m_fa, m_fb;

  function automatic bit f_uses1(logic [6:0] op);
    return op inside {O_OP, O_IMM, O_LD, O_ST, O_BR, O_JALR};
  endfunction
  function automatic bit f_uses2(logic [6:0] op);
    return op inside {O_OP, O_ST, O_BR};
  endfunction
  function automatic bit f_writes(logic [6:0] op, logic [4:0] rd);
    return (rd != 0) && (op inside {O_OP, O_IMM, O_LD, O_JALR, O_JAL, O_LUI, O_AUI});
  endfunction
  function automatic logic [1:0] src_fwd(bit used, logic [4:0] s);
    if (!used || s == 0) return 2'd0;
    if (m_ex_v && f_writes(m_ex_op, m_ex_rd) && m_ex_rd == s) return 2'd1;
    if (m_mem_v && f_writes(m_mem_op, m_mem_rd) && m_mem_rd == s) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_ex_v = 0; m_mem_v = 0; m_ex_op = 0; m_mem_op = 0; m_ex_rd = 0; m_mem_rd = 0;
    m_mode = 0; m_left = 0; m_fa = 0; m_fb = 0;
  endtask

  // One clock: drive, check vs model on the falling edge, advance the model.
  task automatic apply(input logic rst, v, input logic [6:0] op,
                       input logic [4:0] rs1, rs2, rd, input logic redir, busy,
                       output outs_t act);
    outs_t exp;
    bit hz, iss;
    logic [1:0] nfa, nfb;
    reset = rst; bus.id_valid = v; bus.id_opcode = op; bus.id_rs1 = rs1;
    bus.id_rs2 = rs2; bus.id_rd = rd; bus.ex_redirect = redir; bus.mem_busy = busy;
    @(negedge clk);
    hz = v && m_ex_v && m_ex_op == O_LD && m_ex_rd != 0 &&
         ((f_uses1(op) && rs1 == m_ex_rd) || (f_uses2(op) && rs2 == m_ex_rd));
    exp.fa = m_fa; exp.fb = m_fb; exp.halted = (m_mode == 2);
    if (!rst)                      exp.ctl = C_Z;
    else if (m_mode == 2 || busy)  exp.ctl = C_F;
    else if (redir)                exp.ctl = C_R;
    else if (m_mode == 1 || hz)    exp.ctl = C_S;
    else                           exp.ctl = C_N;
    act = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_flush, bus.pipe_freeze,
           bus.fwd_a, bus.fwd_b, bus.halted};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL model cyc=%0d got=%b want=%b", cyc, act, exp);
    end
    if (!rst) model_reset();
    else if (!(m_mode == 2 || busy)) begin
      iss = v && !redir && m_mode == 0 && !hz;
      nfa = iss ? src_fwd(f_uses1(op), rs1) : 2'd0;
      nfb = iss ? src_fwd(f_uses2(op), rs2) : 2'd0;
      m_mem_v = m_ex_v; m_mem_op = m_ex_op; m_mem_rd = m_ex_rd;
      m_ex_v = iss; m_ex_op = op; m_ex_rd = rd;
      m_fa = nfa; m_fb = nfb;
      if (redir) m_mode = 0;
      else if (m_mode == 1) begin
        if (m_left == 1) m_mode = 2; else m_left--;
      end else if (iss && op == O_SYS) begin
        m_mode = 1; m_left = DC;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  vec_t tbl[$];
  task automatic row(input logic rst, v, input logic [6:0] op, input logic [4:0] rs1, rs2, rd,
                     input logic redir, busy, input logic [4:0] ctl,
                     input logic [1:0] fa, fb, input logic h);
    vec_t t;
    t.rst = rst; t.v = v; t.op = op; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
    t.redir = redir; t.busy = busy; t.exp = {ctl, fa, fb, h};
    tbl.push_back(t);
  endtask

  initial begin
    outs_t act;
    logic [6:0] ops [11];
    ops = '{O_OP, O_IMM, O_LD, O_ST, O_BR, O_JALR, O_JAL, O_LUI, O_AUI, O_SYS, 7'h7F};

    //   rst v  op     rs1 rs2 rd redir busy  ctl  fa fb h
    row(0, 0, 0,      0, 0, 0,  0, 0,  C_Z, 0, 0, 0);  // reset state
    row(1, 1, O_OP,   1, 2, 5,  0, 0,  C_N, 0, 0, 0);  // add x5,x1,x2
    row(1, 1, O_OP,   5, 3, 6,  0, 0,  C_N, 0, 0, 0);  // sub x6,x5,x3
    row(1, 0, 0,      0, 0, 0,  0, 0,  C_N, 1, 0, 0);  // sub in EX: EX_MEM/NONE
    row(1, 0, 0,      0, 0, 0,  0, 0,  C_N, 0, 0, 0);
    row(1, 1, O_LD,   1, 0, 7,  0, 0,  C_N, 0, 0, 0);  // lw x7
    row(1, 1, O_OP,   7, 7, 8,  0, 0,  C_S, 0, 0, 0);  // add x8,x7,x7 stalls
    row(1, 1, O_OP,   7, 7, 8,  0, 0,  C_N, 0, 0, 0);  // reissue
    row(1, 0, 0,      0, 0, 0,  0, 0,  C_N, 2, 2, 0);  // MEM_WB both
    row(1, 0, 0,      0, 0, 0,  0, 0,  C_N, 0, 0, 0);
    row(1, 1, O_LD,   1, 0, 0,  0, 0,  C_N, 0, 0, 0);  // lw x0
    row(1, 1, O_OP,   0, 0, 9,  0, 0,  C_N, 0, 0, 0);  // add x9,x0,x0 no stall
    row(1, 0, 0,      0, 0, 0,  0, 0,  C_N, 0, 0, 0);
    row(1, 1, O_LD,   1, 0, 7,  0, 0,  C_N, 0, 0, 0);  // lw x7
    row(1, 1, O_OP,   7, 7, 8,  1, 0,  C_R, 0, 0, 0);  // load-use + redirect
    row(1, 0, 0,      0, 0, 0,  0, 0,  C_N, 0, 0, 0);  // no extra stall
    row(1, 1, O_OP,   1, 2, 5,  0, 0,  C_N, 0, 0, 0);  // add x5
    row(1, 1, O_OP,   5, 3, 6,  0, 0,  C_N, 0, 0, 0);  // sub x6,x5,x3
    row(1, 1, O_OP,   6, 5, 10, 0, 1,  C_F, 1, 0, 0);  // mem_busy x4
    row(1, 1, O_OP,   6, 5, 10, 0, 1,  C_F, 1, 0, 0);
    row(1, 1, O_OP,   6, 5, 10, 0, 1,  C_F, 1, 0, 0);
    row(1, 1, O_OP,   6, 5, 10, 0, 1,  C_F, 1, 0, 0);
    row(1, 1, O_OP,   6, 5, 10, 0, 0,  C_N, 1, 0, 0);  // add x10,x6,x5 issues
    row(1, 0, 0,      0, 0, 0,  0, 0,  C_N, 1, 2, 0);
    row(1, 1, O_SYS,  0, 0, 0,  0, 0,  C_N, 0, 0, 0);  // ecall
    row(1, 0, 0,      0, 0, 0,  0, 0,  C_S, 0, 0, 0);  // drain 1
    row(1, 0, 0,      0, 0, 0,  0, 0,  C_S, 0, 0, 0);  // drain 2
    row(1, 0, 0,      0, 0, 0,  0, 0,  C_S, 0, 0, 0);  // drain 3
    row(1, 1, O_OP,   1, 2, 3,  0, 0,  C_F, 0, 0, 1);  // halted
    row(1, 1, O_OP,   1, 2, 3,  1, 0,  C_F, 0, 0, 1);  // redirect ignored
    row(0, 0, 0,      0, 0, 0,  0, 0,  C_Z, 0, 0, 1);  // reset out of HALTED
    row(1, 0, 0,      0, 0, 0,  0, 0,  C_N, 0, 0, 0);
    row(1, 1, O_SYS,  0, 0, 0,  0, 0,  C_N, 0, 0, 0);  // ecall
    row(1, 0, 0,      0, 0, 0,  1, 0,  C_R, 0, 0, 0);  // redirect squashes drain
    row(1, 0, 0,      0, 0, 0,  0, 0,  C_N, 0, 0, 0);
    row(1, 1, O_LD,   1, 0, 4,  0, 0,  C_N, 0, 0, 0);  // lw x4
    row(1, 1, O_ST,   2, 4, 0,  0, 0,  C_S, 0, 0, 0);  // sw x4,(x2): rs2 hazard
    row(1, 1, O_ST,   2, 4, 0,  0, 0,  C_N, 0, 0, 0);
    row(1, 0, 0,      0, 0, 0,  0, 0,  C_N, 0, 2, 0);
    row(1, 1, O_OP,   1, 2, 5,  0, 0,  C_N, 0, 0, 0);  // add x5
    row(1, 1, O_IMM,  5, 5, 5,  0, 0,  C_N, 0, 0, 0);  // addi x5,x5 (rs2 unused)
    row(1, 1, O_OP,   5, 5, 11, 0, 0,  C_N, 1, 0, 0);  // add x11,x5,x5
    row(1, 0, 0,      0, 0, 0,  0, 0,  C_N, 1, 1, 0);  // EX entry wins

    // Initial reset edge brings the DUT out of X; not compared.
    reset = 0; bus.id_valid = 0; bus.id_opcode = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
    bus.id_rd = 0; bus.ex_redirect = 0; bus.mem_busy = 0;
    @(posedge clk); #1;
    model_reset();

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].v, tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
            tbl[i].redir, tbl[i].busy, act);
      total++;
      if (act !== tbl[i].exp) begin
        bad++;
        $display("FAIL vec[%0d] got=%b want=%b", i, act, tbl[i].exp);
      end
    end

    for (int k = 0; k < 600; k++) begin
      apply(($urandom % 40) != 0, $urandom % 4 != 0, ops[$urandom % 11],
            5'($urandom % 4), 5'($urandom % 4), 5'($urandom % 4),
            ($urandom % 9) == 0, ($urandom % 7) == 0, act);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
